// File: rtl/mult_div_requester_if.sv
// Signal bundle between the request/response ports, the requester and the go/done
// multiply/divide unit. master is the requester's view; slave is the environment's.
interface mult_div_requester_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [31:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        go;
  logic        div_mult;
  logic [31:0] ent_32;
  logic [15:0] ent_16;
  logic        done;
  logic [31:0] sal_32;
  logic        busy;

  modport master (
    input  req_valid, req_op, req_a, req_b, rsp_ready, done, sal_32,
    output req_ready, rsp_valid, rsp_data, rsp_timeout, go, div_mult,
           ent_32, ent_16, busy
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, rsp_ready, done, sal_32,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout, go, div_mult,
           ent_32, ent_16, busy
  );
endinterface

// File: rtl/mult_div_requester.sv
// Initiator for a go/done multiply/divide unit: one operation at a time, four-phase
// go/done handshake, valid/ready request and response ports, watchdog on both phases.
module mult_div_requester #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  mult_div_requester_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESPOND} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              go_q, go_d;
  logic              div_mult_q, div_mult_d;
  logic [31:0]       ent_32_q, ent_32_d;
  logic [15:0]       ent_16_q, ent_16_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready;

  // A unit still showing done from an aborted or reset operation blocks new issues.
  assign req_ready = (state_q == IDLE) && !bus.done && reset_L;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= IDLE;
      go_q          <= 1'b0;
      div_mult_q    <= 1'b0;
      ent_32_q      <= '0;
      ent_16_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      go_q          <= go_d;
      div_mult_q    <= div_mult_d;
      ent_32_q      <= ent_32_d;
      ent_16_q      <= ent_16_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    go_d          = go_q;
    div_mult_d    = div_mult_q;
    ent_32_d      = ent_32_q;
    ent_16_d      = ent_16_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready) begin
          div_mult_d = bus.req_op;
          ent_32_d   = bus.req_a;
          ent_16_d   = bus.req_b;
          go_d       = 1'b1;
          cnt_d      = '0;
          state_d    = ISSUE;
        end
      end

      // done has priority over a watchdog expiry in the same cycle.
      ISSUE: begin
        if (bus.done) begin
          rsp_data_d    = bus.sal_32;
          rsp_timeout_d = 1'b0;
          go_d          = 1'b0;
          cnt_d         = '0;
          state_d       = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          go_d          = 1'b0;
          cnt_d         = '0;
          state_d       = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RELEASE: begin
        if (!bus.done) begin
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = RESPOND;
        end else if (cnt_q == CNT_LAST) begin
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          cnt_d         = '0;
          state_d       = RESPOND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESPOND: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.go          = go_q;
  assign bus.div_mult    = div_mult_q;
  assign bus.ent_32      = ent_32_q;
  assign bus.ent_16      = ent_16_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mult_div_requester.sv
// Directed bench for mult_div_requester: expected responses go into a scoreboard queue
// and a separate monitor pops and compares them on every response handshake.
module tb_mult_div_requester;

  typedef struct packed {
    logic [31:0] data;
    logic        timeout;
  } exp_t;

  logic clk;
  logic reset_L;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  // 0: zero-delay unit, 1: done only from done_force, 2: done two cycles after go
  int          unit_mode;
  logic        done_force;
  logic [2:0]  dly_cnt;
  logic [31:0] unit_result;

  mult_div_requester_if bus();

  mult_div_requester #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!bus.go) dly_cnt <= '0;
    else if (dly_cnt != 3'd7) dly_cnt <= dly_cnt + 3'd1;
  end

  always_comb begin
    logic signed [63:0] prod;
    prod = $signed(bus.ent_32) * $signed(bus.ent_16);
    unit_result = '0;
    if (bus.div_mult) unit_result = prod[31:0];
    else if (bus.ent_16 != 16'd0) unit_result = $signed(bus.ent_32) / $signed(bus.ent_16);
  end

  assign bus.sal_32 = unit_result;
  assign bus.done   = done_force ||
                      (unit_mode == 0 && bus.go) ||
                      (unit_mode == 2 && bus.go && dly_cnt >= 3'd2);

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Response monitor, decoupled from the stimulus process.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid && exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp actual data=0x%08h timeout=%0b required no response",
                 bus.rsp_data, bus.rsp_timeout);
      end else if (bus.rsp_valid && bus.rsp_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.rsp_data !== e.data || bus.rsp_timeout !== e.timeout) begin
          errors++;
          $display("[TB] FAIL rsp actual data=0x%08h timeout=%0b expected data=0x%08h timeout=%0b",
                   bus.rsp_data, bus.rsp_timeout, e.data, e.timeout);
        end
      end
    end
  end

  // Returns one cycle after the accepting edge (E0 + 1).
  task automatic apply_stimulus(input logic op, input logic [31:0] a, input logic [15:0] b,
                                input bit expect_rsp, input logic [31:0] exp_data,
                                input logic exp_to);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    if (expect_rsp) exp_q.push_back('{data: exp_data, timeout: exp_to});
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_output("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 50 && !idle; i++) begin
      @(negedge clk);
      if (!bus.busy) idle = 1'b1;
    end
    check_output(name, {31'd0, idle}, 32'd1);
  endtask

  task automatic count_go(input int window, output int cycles);
    cycles = 0;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (bus.go) begin
        cycles++;
        check_output("ent_32_stable", bus.ent_32, 32'hFFFFFFFD);
        check_output("ent_16_stable", {16'd0, bus.ent_16}, 32'h5);
      end
    end
  endtask

  initial begin
    int   go_cycles;
    logic seen;
    checks = 0;
    errors = 0;
    unit_mode = 1;
    done_force = 1'b1;
    reset_L = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op = 1'b1;
    bus.req_a = 32'h5;
    bus.req_b = 16'h3;
    bus.rsp_ready = 1'b0;

    // Reset with a pending request and done asserted
    repeat (2) @(negedge clk);
    check_output("rst_go", {31'd0, bus.go}, 32'd0);
    check_output("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_output("rst_rsp_data", bus.rsp_data, 32'd0);
    check_output("rst_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
    check_output("rst_ent_32", bus.ent_32, 32'd0);
    check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_output("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    reset_L = 1'b1;
    @(negedge clk);
    check_output("rst_done_blocks", {31'd0, bus.req_ready}, 32'd0);
    check_output("rst_no_accept", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    done_force = 1'b0;
    @(negedge clk);
    check_output("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Divide 100 / 7 with a zero-delay unit
    unit_mode = 0;
    bus.rsp_ready = 1'b1;
    apply_stimulus(1'b0, 32'd100, 16'd7, 1'b1, 32'h0000000E, 1'b0);
    @(negedge clk);
    check_output("div_go_e0", {31'd0, bus.go}, 32'd1);
    check_output("div_div_mult", {31'd0, bus.div_mult}, 32'd0);
    check_output("div_ent_32", bus.ent_32, 32'd100);
    check_output("div_ent_16", {16'd0, bus.ent_16}, 32'd7);
    @(negedge clk);
    check_output("div_go_e1", {31'd0, bus.go}, 32'd0);
    check_output("div_rsp_e1", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    check_output("div_rsp_e2", {31'd0, bus.rsp_valid}, 32'd1);
    @(negedge clk);
    check_output("div_rsp_e3", {31'd0, bus.rsp_valid}, 32'd0);
    check_output("div_idle_e3", {31'd0, bus.busy}, 32'd0);

    // Signed multiply -3 * 5 with a unit that answers after three go cycles
    unit_mode = 2;
    apply_stimulus(1'b1, 32'hFFFFFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b0);
    count_go(10, go_cycles);
    check_output("mul_go_cycles", go_cycles, 32'd3);
    wait_idle("mul_idle");

    // Response backpressure
    unit_mode = 0;
    bus.rsp_ready = 1'b0;
    apply_stimulus(1'b0, 32'h12345678, 16'h0010, 1'b1, 32'h01234567, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check_output("bp_rsp_valid", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check_output("bp_hold_data", bus.rsp_data, 32'h01234567);
      check_output("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check_output("bp_go", {31'd0, bus.go}, 32'd0);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("bp_released_busy", {31'd0, bus.busy}, 32'd0);
    check_output("bp_released_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // Silent unit: watchdog aborts ISSUE after four cycles
    unit_mode = 1;
    apply_stimulus(1'b1, 32'd3, 16'd3, 1'b1, 32'd0, 1'b1);
    go_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.go) go_cycles++;
    end
    check_output("silent_go_cycles", go_cycles, 32'd4);
    wait_idle("silent_idle");

    // done stuck high after capture: RELEASE times out, IDLE waits for done to fall
    apply_stimulus(1'b1, 32'd6, 16'd7, 1'b1, 32'd42, 1'b1);
    done_force = 1'b1;
    wait_idle("stuck_idle");
    @(negedge clk);
    check_output("stuck_req_ready", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    done_force = 1'b0;
    @(negedge clk);
    check_output("stuck_cleared_ready", {31'd0, bus.req_ready}, 32'd1);

    // Reset during ISSUE: go drops at once, no response follows
    apply_stimulus(1'b0, 32'd50, 16'd5, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    check_output("midrst_go_before", {31'd0, bus.go}, 32'd1);
    #1 reset_L = 1'b0;
    #1;
    check_output("midrst_go_drop", {31'd0, bus.go}, 32'd0);
    check_output("midrst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    reset_L = 1'b1;
    repeat (10) @(negedge clk);
    check_output("midrst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    check_output("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
